i2c_master_scheduler: RTL and testbench

I2C_MASTER_SCHEDULER -- requirements
Module: i2c_master_scheduler

---
 rtl/i2c_master_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_master_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_scheduler.sv
// Two-requester I2C transaction scheduler: arbitrates round-robin, then sequences
// START / address / data / STOP commands to a byte-level I2C engine with a per-command timeout.
module i2c_master_scheduler #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             iclk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [6:0]       addr0,
  input  logic [6:0]       addr1,
  input  logic             rw0,
  input  logic             rw1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       wdata0,
  input  logic [7:0]       wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             wnext,
  output logic [7:0]       rdata,
  output logic             rvalid,
  output logic             done,
  output logic             err,
  output logic [2:0]       eng_cmd,
  output logic             eng_valid,
  output logic [7:0]       eng_din,
  input  logic             eng_busy,
  input  logic             eng_done,
  input  logic             eng_nack,
  input  logic [7:0]       eng_dout
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_ADDR, S_DATA, S_STOP, S_FIN
  } state_t;

  state_t           state, state_nx;
  logic             issued, issued_nx;
  logic             error, error_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [6:0]       addr_l, addr_nx;
  logic             rw_l, rw_nx;
  logic             last, last_nx;
  logic             gnt0_nx, gnt1_nx;
  logic [TW-1:0]    tcnt, tcnt_nx;
  logic             cmd_state, wait_done, got, timed_out, last_byte, win;
  logic [2:0]       cmd_sel;
  logic [7:0]       din_sel;

  // Each command state has two phases: issue (issued=0) and wait for eng_done (issued=1).
  always_comb begin
    cmd_state = (state == S_START) || (state == S_ADDR) ||
                (state == S_DATA)  || (state == S_STOP);
    eng_valid = cmd_state && !issued && !eng_busy;
    wait_done = cmd_state && issued;
    got       = wait_done && eng_done;
    timed_out = wait_done && !eng_done && (tcnt == TW'(TIMEOUT - 1));
    last_byte = (cnt == LEN_W'(1));

    cmd_sel = 3'd0;
    din_sel = 8'h00;
    unique case (state)
      S_START: cmd_sel = 3'd1;
      S_ADDR: begin
        cmd_sel = 3'd2;
        din_sel = {addr_l, rw_l};
      end
      S_DATA: begin
        if (rw_l) begin
          cmd_sel = last_byte ? 3'd4 : 3'd3;
        end else begin
          cmd_sel = 3'd2;
          din_sel = gnt1 ? wdata1 : wdata0;
        end
      end
      S_STOP:  cmd_sel = 3'd5;
      default: cmd_sel = 3'd0;
    endcase

    eng_cmd = eng_valid ? cmd_sel : '0;
    eng_din = eng_valid ? din_sel : '0;
    wnext   = got && (state == S_DATA) && !rw_l && !eng_nack;
    done    = (state == S_FIN);
    err     = done && error;
  end

  always_comb begin
    state_nx  = state;
    issued_nx = issued;
    error_nx  = error;
    cnt_nx    = cnt;
    addr_nx   = addr_l;
    rw_nx     = rw_l;
    last_nx   = last;
    gnt0_nx   = gnt0;
    gnt1_nx   = gnt1;
    tcnt_nx   = tcnt;
    win       = 1'b0;

    if (eng_valid) begin
      issued_nx = 1'b1;
      tcnt_nx   = TW'(1);
    end else if (wait_done && !eng_done) begin
      tcnt_nx = tcnt + TW'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (req0 || req1) state_nx = S_ARB;
      end
      S_ARB: begin
        win = (req0 && req1) ? ~last : req1;
        if (req0 || req1) begin
          gnt0_nx   = ~win;
          gnt1_nx   = win;
          last_nx   = win;
          addr_nx   = win ? addr1 : addr0;
          rw_nx     = win ? rw1 : rw0;
          cnt_nx    = win ? len1 : len0;
          issued_nx = 1'b0;
          error_nx  = 1'b0;
          state_nx  = S_START;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (got) begin
          issued_nx = 1'b0;
          state_nx  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (got) begin
          issued_nx = 1'b0;
          if (eng_nack) begin
            error_nx = 1'b1;
            state_nx = S_STOP;
          end else if (cnt == '0) begin
            state_nx = S_STOP;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (got) begin
          issued_nx = 1'b0;
          if (!rw_l && eng_nack) begin
            error_nx = 1'b1;
            state_nx = S_STOP;
          end else begin
            cnt_nx = cnt - LEN_W'(1);
            if (last_byte) state_nx = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (got) begin
          issued_nx = 1'b0;
          state_nx  = S_FIN;
        end
      end
      S_FIN: begin
        gnt0_nx   = 1'b0;
        gnt1_nx   = 1'b0;
        error_nx  = 1'b0;
        issued_nx = 1'b0;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // A silent engine abandons the bus without STOP; FIN reports it as an error.
    if (timed_out) begin
      state_nx  = S_FIN;
      error_nx  = 1'b1;
      issued_nx = 1'b0;
    end
  end

  always_ff @(posedge iclk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      issued <= 1'b0;
      error  <= 1'b0;
      cnt    <= '0;
      addr_l <= '0;
      rw_l   <= 1'b0;
      last   <= 1'b1;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      tcnt   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      state  <= state_nx;
      issued <= issued_nx;
      error  <= error_nx;
      cnt    <= cnt_nx;
      addr_l <= addr_nx;
      rw_l   <= rw_nx;
      last   <= last_nx;
      gnt0   <= gnt0_nx;
      gnt1   <= gnt1_nx;
      tcnt   <= tcnt_nx;
      rvalid <= got && (state == S_DATA) && rw_l;
      if (got && (state == S_DATA) && rw_l) rdata <= eng_dout;
    end
  end

endmodule

// File: tb/tb_i2c_master_scheduler.sv
// Bench for i2c_master_scheduler: an engine responder plus a transaction-level model that
// predicts command sequences, read data, wnext counts, grants and error outcomes.
module tb_i2c_master_scheduler;
  localparam int LW  = 4;
  localparam int TMO = 20;

  logic          iclk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 0, req1 = 0, rw0 = 0, rw1 = 0;
  logic [6:0]    addr0 = '0, addr1 = '0;
  logic [LW-1:0] len0 = '0, len1 = '0;
  logic [7:0]    wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, wnext, rvalid, done, err, eng_valid;
  logic [7:0]    rdata, eng_din;
  logic [2:0]    eng_cmd;
  logic          eng_busy = 0, eng_done = 0, eng_nack = 0;
  logic [7:0]    eng_dout = '0;

  i2c_master_scheduler #(.LEN_W(LW), .TIMEOUT(TMO)) dut (
    .iclk(iclk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .rw0(rw0), .rw1(rw1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .wnext(wnext), .rdata(rdata), .rvalid(rvalid), .done(done), .err(err),
    .eng_cmd(eng_cmd), .eng_valid(eng_valid), .eng_din(eng_din),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack), .eng_dout(eng_dout)
  );

  initial forever #5 iclk = ~iclk;

  int total = 0, bad = 0, cyc = 0;
  initial forever begin @(posedge iclk); cyc++; end

  // Requester slots: what each requester asks for and how the engine will treat it.
  logic [6:0] s_addr[2];
  logic       s_rw[2];
  logic [3:0] s_len[2];
  logic [7:0] s_wd[2][16];
  logic [7:0] s_rd[2][16];
  int         s_nack[2];
  bit         s_hold[2];
  bit         active[2];
  int         widx[2];
  int         last_m = 1, cur = 0, exp_gnt = 0, cmd_idx = 0;
  bit         rand_mode = 0;

  int         exp_cmd[$];
  logic [7:0] exp_din[$];
  logic [7:0] exp_rd[$];
  int         exp_wnext;
  bit         exp_err, exp_tmo;

  int         log_cmd[$];
  logic [7:0] log_din[$];
  logic [7:0] log_rd[$];
  int         log_gnt = -1, wn_cnt = 0, valid_cyc = 0;
  bit         last_err = 0, done_seen = 0;

  int         t1c[5] = '{1, 2, 2, 2, 5};
  logic [7:0] t1d[3] = '{8'hA0, 8'hAA, 8'hBB};
  int         t2c[6] = '{1, 2, 3, 3, 4, 5};
  logic [7:0] t2r[3] = '{8'h11, 8'h22, 8'h33};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {gnt0, gnt1, wnext, rvalid, done, err, eng_valid}, 0);
    chk({tag, "_cmd"}, eng_cmd, 0);
    chk({tag, "_din"}, eng_din, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // Transaction-level prediction of everything the scheduler should do for slot k.
  function automatic void build_model(input int k);
    exp_cmd.delete(); exp_din.delete(); exp_rd.delete();
    exp_wnext = 0; exp_err = 0; exp_tmo = 0;
    exp_cmd.push_back(1); exp_din.push_back(8'h00);
    if (s_hold[k]) begin
      exp_err = 1; exp_tmo = 1;
      return;
    end
    exp_cmd.push_back(2); exp_din.push_back({s_addr[k], s_rw[k]});
    if (s_nack[k] == 1) exp_err = 1;
    else
      for (int i = 0; i < int'(s_len[k]); i++) begin
        if (s_rw[k]) begin
          exp_cmd.push_back(i == int'(s_len[k]) - 1 ? 4 : 3);
          exp_din.push_back(8'h00);
          exp_rd.push_back(s_rd[k][i]);
        end else begin
          exp_cmd.push_back(2); exp_din.push_back(s_wd[k][i]);
          if (s_nack[k] == i + 2) begin exp_err = 1; break; end
          exp_wnext++;
        end
      end
    exp_cmd.push_back(5); exp_din.push_back(8'h00);
  endfunction

  function automatic int pick();
    if (active[0] && active[1]) return (last_m == 1) ? 0 : 1;
    return active[1] ? 1 : 0;
  endfunction

  task automatic set_req(input int k, input logic v);
    if (k == 0) req0 = v; else req1 = v;
  endtask

  task automatic drive_in(input int k, input logic [6:0] a, input logic r, input logic [3:0] l);
    if (k == 0) begin addr0 = a; rw0 = r; len0 = l; end
    else begin addr1 = a; rw1 = r; len1 = l; end
  endtask

  task automatic set_slot(input int k, input logic [6:0] a, input logic r, input logic [3:0] l,
                          input int nk, input bit hold);
    s_addr[k] = a; s_rw[k] = r; s_len[k] = l; s_nack[k] = nk; s_hold[k] = hold;
    for (int i = 0; i < 16; i++) begin
      s_wd[k][i] = 8'($urandom);
      s_rd[k][i] = 8'($urandom);
    end
    widx[k] = 0;
    drive_in(k, a, r, l);
    active[k] = 1;
    set_req(k, 1'b1);
  endtask

  task automatic prep(output int w);
    w = pick();
    last_m = w; cur = w; exp_gnt = w;
    build_model(w);
    log_cmd.delete(); log_din.delete(); log_rd.delete();
    log_gnt = -1; cmd_idx = 0; wn_cnt = 0; done_seen = 0;
  endtask

  task automatic serve_one();
    int w;
    bit drop;
    prep(w);
    drop = rand_mode && ($urandom_range(0, 5) == 0);
    for (int n = 0; n < 2000 && !done_seen; n++) begin
      @(posedge iclk); #1;
      if ((w == 0 && gnt0) || (w == 1 && gnt1)) begin
        if (rand_mode) drive_in(w, 7'($urandom), 1'($urandom), 4'($urandom));
        if (drop) set_req(w, 1'b0);
      end
    end
    chk("done_seen", done_seen, 1);
    set_req(w, 1'b0);
    active[w] = 0;
  endtask

  // Requester data: advance to the next write byte after each wnext.
  initial forever begin
    @(posedge iclk); #1;
    wdata0 = s_wd[0][widx[0] & 15];
    wdata1 = s_wd[1][widx[1] & 15];
  end

  // Engine responder: busy after a command, eng_done after a random delay.
  initial forever begin
    int idx, d;
    @(negedge iclk);
    if (reset === 1'b1 && eng_valid === 1'b1 && !s_hold[cur]) begin
      idx = cmd_idx; cmd_idx++;
      @(posedge iclk); #1;
      eng_busy = 1'b1;
      d = $urandom_range(0, 3);
      repeat (d) begin @(posedge iclk); #1; end
      eng_busy = 1'b0;
      eng_done = 1'b1;
      eng_nack = (idx == s_nack[cur]);
      eng_dout = (idx >= 2) ? s_rd[cur][(idx - 2) & 15] : 8'($urandom);
      @(posedge iclk); #1;
      eng_done = 1'b0;
      eng_nack = 1'b0;
      eng_dout = 8'($urandom);
    end
  end

  // Compare process: every cycle out of reset.
  initial forever begin
    int c;
    logic [7:0] d;
    @(negedge iclk);
    if (reset === 1'b1) begin
      if (gnt0 || gnt1) begin
        chk("gnt", {gnt1, gnt0}, (exp_gnt == 1) ? 2'b10 : 2'b01);
        if (log_gnt < 0) log_gnt = gnt1 ? 1 : 0;
      end
      if (eng_valid) begin
        chk("valid_while_busy", eng_busy, 0);
        log_cmd.push_back(int'(eng_cmd)); log_din.push_back(eng_din);
        valid_cyc = cyc;
        if (exp_cmd.size() == 0) chk("extra_cmd", eng_valid, 0);
        else begin
          c = exp_cmd.pop_front(); d = exp_din.pop_front();
          chk("eng_cmd", eng_cmd, c);
          if (c == 2) chk("eng_din", eng_din, d);
        end
      end
      if (rvalid) begin
        log_rd.push_back(rdata);
        if (exp_rd.size() == 0) chk("extra_rvalid", rvalid, 0);
        else chk("rdata", rdata, exp_rd.pop_front());
      end
      if (wnext) begin
        wn_cnt++;
        widx[exp_gnt]++;
      end
      if (done) begin
        chk("err", err, exp_err);
        chk("cmds_left", exp_cmd.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("wnext_count", wn_cnt, exp_wnext);
        if (exp_tmo) chk("timeout_latency", cyc - valid_cyc, TMO);
        last_err = err;
        done_seen = 1;
      end
    end
  end

  initial begin
    int w, k, ln, nk;
    logic r;
    s_hold[0] = 0; s_hold[1] = 0; s_nack[0] = -1; s_nack[1] = -1;
    active[0] = 0; active[1] = 0; widx[0] = 0; widx[1] = 0;
    repeat (3) @(negedge iclk);
    check_zero("reset");
    @(posedge iclk); #1;
    reset = 1'b1;
    @(posedge iclk); #1;

    // Both requesters from reset: write to 0x50 wins, then read from 0x21 while req0 stays high.
    set_slot(0, 7'h50, 1'b0, 4'd2, -1, 0);
    s_wd[0][0] = 8'hAA; s_wd[0][1] = 8'hBB;
    set_slot(1, 7'h21, 1'b1, 4'd3, -1, 0);
    s_rd[1][0] = 8'h11; s_rd[1][1] = 8'h22; s_rd[1][2] = 8'h33;
    serve_one();
    chk("t1_first_gnt", log_gnt, 0);
    chk("t1_ncmd", log_cmd.size(), 5);
    for (int i = 0; i < 5 && i < log_cmd.size(); i++) chk("t1_cmd", log_cmd[i], t1c[i]);
    for (int i = 0; i < 3 && i + 1 < log_din.size(); i++) chk("t1_din", log_din[i + 1], t1d[i]);
    chk("t1_wnext", wn_cnt, 2);
    chk("t1_err", last_err, 0);

    set_slot(0, 7'h12, 1'b0, 4'd1, -1, 0);
    serve_one();
    chk("t2_gnt", log_gnt, 1);
    chk("t2_ncmd", log_cmd.size(), 6);
    for (int i = 0; i < 6 && i < log_cmd.size(); i++) chk("t2_cmd", log_cmd[i], t2c[i]);
    if (log_din.size() > 1) chk("t2_addr_byte", log_din[1], 8'h43);
    chk("t2_nrd", log_rd.size(), 3);
    for (int i = 0; i < 3 && i < log_rd.size(); i++) chk("t2_rdata", log_rd[i], t2r[i]);
    chk("t2_err", last_err, 0);
    serve_one();
    chk("t3_gnt", log_gnt, 0);

    // Address NACK: START, address, STOP with error.
    set_slot(0, 7'h3C, 1'b0, 4'd3, 1, 0);
    serve_one();
    chk("nack_ncmd", log_cmd.size(), 3);
    if (log_cmd.size() == 3) chk("nack_stop", log_cmd[2], 5);
    chk("nack_err", last_err, 1);

    // Engine goes silent after START.
    set_slot(1, 7'h44, 1'b1, 4'd2, -1, 1);
    serve_one();
    chk("tmo_ncmd", log_cmd.size(), 1);
    chk("tmo_err", last_err, 1);

    // Reset in the middle of the data phase.
    set_slot(0, 7'h33, 1'b0, 4'd6, -1, 0);
    prep(w);
    for (int n = 0; n < 500 && log_cmd.size() < 3; n++) begin @(posedge iclk); #1; end
    chk("rst_reached_data", log_cmd.size() >= 3, 1);
    reset = 1'b0;
    set_req(0, 1'b0); active[0] = 0;
    #1;
    check_zero("midrst");
    exp_cmd.delete(); exp_din.delete(); exp_rd.delete();
    last_m = 1;
    @(posedge iclk); #1;
    reset = 1'b1;
    repeat (10) begin @(posedge iclk); #1; end
    set_slot(1, 7'h0A, 1'b1, 4'd2, -1, 0);
    serve_one();
    chk("post_rst_ncmd", log_cmd.size(), 5);
    chk("post_rst_err", last_err, 0);

    // Randomized traffic.
    rand_mode = 1;
    for (int it = 0; it < 40; it++) begin
      for (k = 0; k < 2; k++)
        if (!active[k] && ($urandom_range(0, 1) == 1 || (!active[0] && !active[1] && k == 1))) begin
          ln = $urandom_range(0, 5);
          r  = 1'($urandom);
          nk = -1;
          case ($urandom_range(0, 9))
            0: nk = 1;
            1: if (!r && ln > 0) nk = 2 + $urandom_range(0, ln - 1);
            default: nk = -1;
          endcase
          set_slot(k, 7'($urandom), r, 4'(ln), nk, $urandom_range(0, 11) == 0);
        end
      serve_one();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
